// File: rtl/sepia_bmp_writer.sv
// sepia_bmp_writer: serialises sepia-filtered RGB pixels into a BMP pixel-array byte stream.
// Each accepted pixel is saturated to 8 bits per channel and sent as B, G, R. After the last
// pixel of every row, PAD_N zero bytes are added so that each row is a multiple of 4 bytes long.
// Rows are sent in the order they arrive.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   pix_valid/pix_ready   pixel handshake; pix_r/g/b are unclamped colour values
//   byte_valid/byte_ready byte handshake; out_byte is the stream byte
//   row_end               marks the last byte of a row, padding included
//   frame_done            high once the whole frame has been sent, until rst
module sepia_bmp_writer #(
  parameter int unsigned IMG_W = 500,
  parameter int unsigned IMG_H = 333,
  parameter int unsigned IN_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [IN_W-1:0] pix_r,
  input  logic [IN_W-1:0] pix_g,
  input  logic [IN_W-1:0] pix_b,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic [7:0]      out_byte,
  output logic            row_end,
  output logic            frame_done
);

  localparam int unsigned PadN = (4 - ((3 * IMG_W) % 4)) % 4;
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  // Index of the final padding byte; unreachable when PadN is 0.
  localparam logic [1:0] PadLast = 2'((PadN + 3) % 4);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSendB = 3'd1;
  localparam logic [2:0] StSendG = 3'd2;
  localparam logic [2:0] StSendR = 3'd3;
  localparam logic [2:0] StPad   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [1:0]      pad_q, pad_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;

  logic last_col, last_row, byte_xfer;

  function automatic logic [7:0] sat8(input logic [IN_W-1:0] v);
    return (v > IN_W'(255)) ? 8'hFF : v[7:0];
  endfunction

  assign last_col  = (col_q == ColLast);
  assign last_row  = (row_q == RowLast);
  assign byte_xfer = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pad_d   = pad_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (pix_valid) begin
          r_d     = sat8(pix_r);
          g_d     = sat8(pix_g);
          b_d     = sat8(pix_b);
          state_d = StSendB;
        end
      end
      StSendB: if (byte_xfer) state_d = StSendG;
      StSendG: if (byte_xfer) state_d = StSendR;
      StSendR: begin
        if (byte_xfer) begin
          if (!last_col) begin
            col_d   = col_q + ColW'(1);
            state_d = StIdle;
          end else if (PadN != 0) begin
            // Column/row advance is deferred to the end of padding so that the
            // last-row decision below still sees the current row.
            pad_d   = 2'd0;
            state_d = StPad;
          end else begin
            col_d = '0;
            if (last_row) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + RowW'(1);
              state_d = StIdle;
            end
          end
        end
      end
      StPad: begin
        if (byte_xfer) begin
          if (pad_q == PadLast) begin
            col_d = '0;
            if (last_row) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + RowW'(1);
              state_d = StIdle;
            end
          end else begin
            pad_d = pad_q + 2'd1;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      pad_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pad_q   <= pad_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  // All outputs decode the registered state only, so byte_ready never reaches pix_ready.
  always_comb begin
    pix_ready  = (state_q == StIdle);
    byte_valid = 1'b0;
    out_byte   = 8'h00;
    row_end    = 1'b0;
    frame_done = (state_q == StDone);
    unique case (state_q)
      StSendB: begin
        byte_valid = 1'b1;
        out_byte   = b_q;
      end
      StSendG: begin
        byte_valid = 1'b1;
        out_byte   = g_q;
      end
      StSendR: begin
        byte_valid = 1'b1;
        out_byte   = r_q;
        row_end    = last_col && (PadN == 0);
      end
      StPad: begin
        byte_valid = 1'b1;
        row_end    = (pad_q == PadLast);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sepia_bmp_writer.md
SEPIA_BMP_WRITER -- requirements
Module: sepia_bmp_writer

Interface
REQ-001 Parameter IMG_W, default 500, pixels per row.
REQ-002 Parameter IMG_H, default 333, rows per frame.
REQ-003 Parameter IN_W, default 16, width of each unsigned colour input.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pix_valid  input  1  sepia stage presents a pixel.
REQ-007 pix_ready  output  1  writer accepts a pixel this cycle.
REQ-008 pix_r, pix_g, pix_b  input  IN_W each  unsigned sepia results, unclamped, may exceed 255.
REQ-009 byte_valid  output  1  out_byte holds a valid byte.
REQ-010 byte_ready  input  1  downstream sink accepts out_byte.
REQ-011 out_byte  output  8  BMP pixel-array byte stream.
REQ-012 row_end  output  1  qualifies the last byte of each row, including padding.
REQ-013 frame_done  output  1  high from the cycle after the final byte transfer until rst.

Function
REQ-014 A pixel transfer occurs on a cycle where pix_valid and pix_ready are both high; a byte transfer occurs where byte_valid and byte_ready are both high.
REQ-015 On acceptance the block registers each channel saturated: value > 255 becomes 255, otherwise its low 8 bits.
REQ-016 FSM states:
  - IDLE: pix_ready=1, byte_valid=0.
  - SEND_B, SEND_G, SEND_R: byte_valid=1, pix_ready=0.
  - PAD: byte_valid=1, out_byte=0x00.
  - DONE: pix_ready=0, byte_valid=0.
REQ-017 Transitions:
  - IDLE -> SEND_B on pixel transfer.
  - SEND_B -> SEND_G -> SEND_R, each on byte transfer.
  - SEND_R on byte transfer: to PAD if the pixel is last in row and PAD_N>0; else to DONE if last pixel of frame; else to IDLE.
  - PAD -> PAD until PAD_N bytes are sent; then to DONE if last row, else to IDLE.
REQ-018 Byte order per pixel is blue, green, red (BMP order).
REQ-019 PAD_N = (4 - (3*IMG_W mod 4)) mod 4; computed at elaboration. Defaults give 0.
REQ-020 Rows are emitted in arrival order; no row reversal is performed.
REQ-021 The column counter wraps to 0 after IMG_W pixels, at the same time as the row counter increments. The row counter stops at IMG_H-1.
REQ-022 row_end is high with the last red byte when PAD_N=0, else with the last PAD byte; low otherwise.
REQ-023 While byte_valid=1 and byte_ready=0, out_byte, row_end and state shall hold stable; no byte is dropped or duplicated.
REQ-024 Latency: first byte valid 1 cycle after pixel transfer. With byte_ready tied high, throughput is 3 cycles per byte triplet plus 1 IDLE cycle per pixel.
REQ-025 pix_ready is a registered function of state only, with no combinational path from byte_ready.
REQ-026 In DONE, further pix_valid is ignored and the block remains there until rst.

Reset
REQ-027 When rst=1 at a clock edge:
  - state <- IDLE; counters <- 0.
  - byte_valid=0, pix_ready=1 after the edge.
  - out_byte=0x00, row_end=0, frame_done=0.
REQ-028 rst mid-pixel or mid-padding abandons the partial pixel; the next accepted pixel is column 0, row 0.
REQ-029 rst takes priority over any simultaneous pixel or byte transfer.

Verification
REQ-030 Defaults, one pixel R=344, G=300, B=100, byte_ready=1 -> bytes 0x64, 0xFF, 0xFF on consecutive cycles; row_end=0.
REQ-031 IMG_W=3, IMG_H=2, 6 pixels, byte_ready=1 -> 24 bytes total; bytes 10-12 and 22-24 are 0x00; row_end on bytes 12 and 24; frame_done asserted the cycle after byte 24.
REQ-032 Backpressure: byte_ready toggled 1,0,0,1 during a pixel -> each byte held stable while stalled; sequence identical to the unstalled case.
REQ-033 rst asserted while state is SEND_G -> next cycle byte_valid=0, pix_ready=1; a following frame of IMG_W*IMG_H pixels yields the correct byte count and frame_done.
REQ-034 Boundary values: channel inputs 255, 256 and 0xFFFF -> 0xFF; 0 -> 0x00.
REQ-035 After frame_done, 5 extra pix_valid pulses -> no pix_ready, no byte_valid; frame_done stays 1.
